// File: rtl/dmem_responder_pkg.sv
// Shared constants and state encoding for the data-memory responder.
package dmem_responder_pkg;
   localparam int WORD_WIDTH = 32;

   typedef enum logic [1:0] {
      S_IDLE,
      S_GNT_WAIT,
      S_RESP_WAIT,
      S_RESP
   } dmem_state_t;
endpackage

// File: rtl/dmem_sram_be.sv
// Single-port synchronous RAM, per-byte write enables, registered read.
module dmem_sram_be #(
   parameter int WORD_WIDTH  = 32,
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                           clk,
   input  logic                           i_en,
   input  logic                           i_we,
   input  logic [WORD_WIDTH/8-1:0]        i_be,
   input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
   input  logic [WORD_WIDTH-1:0]          i_wdata,
   output logic [WORD_WIDTH-1:0]          o_rdata
);
   import dmem_responder_pkg::*;

   localparam int NB = WORD_WIDTH / 8;

   logic [WORD_WIDTH-1:0] r_mem [DEPTH_WORDS];
   logic [WORD_WIDTH-1:0] r_q;

   always_ff @(posedge clk) begin
      if (i_en) begin
         if (i_we) begin
            for (int b = 0; b < NB; b++) begin
               if (i_be[b]) begin
                  r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
               end
            end
         end else begin
            r_q <= r_mem[i_addr];
         end
      end
   end

   assign o_rdata = r_q;
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: req/gnt/rvalid protocol with configurable
// grant and response wait states, one transaction outstanding.
module dmem_responder #(
   parameter int WORD_WIDTH  = dmem_responder_pkg::WORD_WIDTH,
   parameter int DEPTH_WORDS = 1024,
   parameter int GNT_WAIT    = 0,
   parameter int RESP_WAIT   = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    data_req_i,
   input  logic [WORD_WIDTH-1:0]   data_addr_i,
   input  logic                    data_we_i,
   input  logic [WORD_WIDTH/8-1:0] data_be_i,
   input  logic [WORD_WIDTH-1:0]   data_wdata_i,
   output logic                    data_gnt_o,
   output logic                    data_rvalid_o,
   output logic [WORD_WIDTH-1:0]   data_rdata_o,
   output logic                    data_err_o
);
   import dmem_responder_pkg::*;

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(GNT_WAIT + RESP_WAIT + 2);
   localparam logic [CW-1:0] GW_LAST =
      CW'((GNT_WAIT > 0) ? GNT_WAIT - 1 : 0);
   localparam logic [CW-1:0] RW_LAST =
      CW'((RESP_WAIT > 0) ? RESP_WAIT - 1 : 0);

   dmem_state_t           r_state;
   dmem_state_t           w_state_nxt;
   dmem_state_t           w_after_gnt;
   logic [CW-1:0]         r_cnt;
   logic                  r_we;
   logic                  r_err;
   logic [WORD_WIDTH-1:0] r_rdata;
   logic                  w_gnt;
   logic                  w_grant;
   logic                  w_rvalid;
   logic                  w_oor;
   logic [WORD_WIDTH-1:0] w_sram_q;
   logic [WORD_WIDTH-1:0] w_rdata;

   assign w_oor       = (data_addr_i >> (AW + 2)) != '0;
   assign w_grant     = data_req_i & w_gnt;
   assign w_after_gnt = (RESP_WAIT == 0) ? S_RESP : S_RESP_WAIT;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_RESP: begin
            if (!data_req_i) begin
               w_state_nxt = S_IDLE;
            end else if (GNT_WAIT == 0) begin
               w_state_nxt = w_after_gnt;
            end else begin
               w_state_nxt = S_GNT_WAIT;
            end
         end
         S_GNT_WAIT: begin
            if (!data_req_i) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt == GW_LAST) begin
               w_state_nxt = w_after_gnt;
            end
         end
         S_RESP_WAIT: begin
            if (r_cnt == RW_LAST) begin
               w_state_nxt = S_RESP;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // RESP doubles as IDLE so back-to-back requests can be granted.
   always_comb begin
      w_gnt    = 1'b0;
      w_rvalid = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_gnt = data_req_i && (GNT_WAIT == 0);
         end
         S_GNT_WAIT: begin
            w_gnt = data_req_i && (r_cnt == GW_LAST);
         end
         S_RESP: begin
            w_gnt    = data_req_i && (GNT_WAIT == 0);
            w_rvalid = 1'b1;
         end
         default: begin
            w_gnt    = 1'b0;
            w_rvalid = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_state_nxt == r_state &&
                   (r_state == S_GNT_WAIT ||
                    r_state == S_RESP_WAIT)) begin
         r_cnt <= r_cnt + 1'b1;
      end else begin
         r_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we    <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         if (w_grant) begin
            r_we  <= data_we_i;
            r_err <= w_oor;
         end
         if (w_rvalid) begin
            r_rdata <= w_rdata;
         end
      end
   end

   dmem_sram_be #(
      .WORD_WIDTH  (WORD_WIDTH),
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_sram (
      .clk     (clk),
      .i_en    (w_grant & ~w_oor),
      .i_we    (data_we_i),
      .i_be    (data_be_i),
      .i_addr  (data_addr_i[2 +: AW]),
      .i_wdata (data_wdata_i),
      .o_rdata (w_sram_q)
   );

   assign w_rdata       = (r_we | r_err) ? '0 : w_sram_q;
   assign data_gnt_o    = w_gnt;
   assign data_rvalid_o = w_rvalid;
   assign data_err_o    = w_rvalid & r_err;
   assign data_rdata_o  = w_rvalid ? w_rdata : r_rdata;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: one responder with no waits, one with 2/3 waits.
module tb_dmem_responder;
   logic        clk = 1'b0;
   int          cyc = 0;
   int          n_pass = 0;
   int          n_tot = 0;

   logic        rst_n0, req0, we0, gnt0, rv0, err0;
   logic [3:0]  be0;
   logic [31:0] addr0, wd0, rd0;
   logic        rst_n1, req1, we1, gnt1, rv1, err1;
   logic [3:0]  be1;
   logic [31:0] addr1, wd1, rd1;

   typedef struct {
      logic [31:0] rd;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_responder #(
      .WORD_WIDTH(32), .DEPTH_WORDS(1024),
      .GNT_WAIT(0), .RESP_WAIT(0)
   ) u0 (
      .clk(clk), .rst_n(rst_n0),
      .data_req_i(req0), .data_addr_i(addr0),
      .data_we_i(we0), .data_be_i(be0),
      .data_wdata_i(wd0), .data_gnt_o(gnt0),
      .data_rvalid_o(rv0), .data_rdata_o(rd0),
      .data_err_o(err0)
   );

   dmem_responder #(
      .WORD_WIDTH(32), .DEPTH_WORDS(1024),
      .GNT_WAIT(2), .RESP_WAIT(3)
   ) u1 (
      .clk(clk), .rst_n(rst_n1),
      .data_req_i(req1), .data_addr_i(addr1),
      .data_we_i(we1), .data_be_i(be1),
      .data_wdata_i(wd1), .data_gnt_o(gnt1),
      .data_rvalid_o(rv1), .data_rdata_o(rd1),
      .data_err_o(err1)
   );

   task automatic chk(input string nm, input logic ok,
                      input logic [31:0] act,
                      input logic [31:0] req);
      n_tot++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %h, need %h (t=%0t)",
                    nm, act, req, $time);
   endtask

   task automatic issue0(input logic we, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd,
                         input logic [31:0] erd, input logic eerr);
      int n;
      n = 0;
      req0 = 1'b1; we0 = we; addr0 = a; be0 = be; wd0 = wd;
      @(negedge clk);
      while (!gnt0 && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("u0 gnt latency", gnt0 && n == 0, 32'(n), 32'd0);
      if (gnt0) q0.push_back('{erd, eerr, cyc + 1});
      @(posedge clk);
      #1;
   endtask

   task automatic issue1(input logic we, input logic [31:0] a,
                         input logic [31:0] wd,
                         input logic [31:0] erd, input bit push,
                         output int n);
      n = 0;
      req1 = 1'b1; we1 = we; addr1 = a; be1 = 4'hF; wd1 = wd;
      @(negedge clk);
      while (!gnt1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (!gnt1) chk("u1 gnt timeout", 1'b0, 32'(n), 32'd0);
      if (gnt1 && push) q1.push_back('{erd, 1'b0, cyc + 4});
      @(posedge clk);
      #1;
   endtask

   task automatic idle0(input int k);
      req0 = 1'b0;
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic idle1(input int k);
      req1 = 1'b0;
      repeat (k) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin : mon0
      exp_t e;
      if (rv0) begin
         if (q0.size() == 0) begin
            chk("u0 unexpected rvalid", 1'b0, rd0, 32'd0);
         end else begin
            e = q0.pop_front();
            chk("u0 rdata", rd0 == e.rd, rd0, e.rd);
            chk("u0 err", err0 == e.err, 32'(err0), 32'(e.err));
            chk("u0 rvalid cycle", cyc == e.cyc,
                32'(cyc), 32'(e.cyc));
         end
      end
   end

   always @(negedge clk) begin : mon1
      exp_t e;
      if (rv1) begin
         if (q1.size() == 0) begin
            chk("u1 unexpected rvalid", 1'b0, rd1, 32'd0);
         end else begin
            e = q1.pop_front();
            chk("u1 rdata", rd1 == e.rd, rd1, e.rd);
            chk("u1 err", err1 == e.err, 32'(err1), 32'(e.err));
            chk("u1 rvalid cycle", cyc == e.cyc,
                32'(cyc), 32'(e.cyc));
         end
      end
   end

   initial begin
      int n;
      rst_n0 = 1'b0; rst_n1 = 1'b0;
      req0 = 0; we0 = 0; be0 = 0; addr0 = 0; wd0 = 0;
      req1 = 0; we1 = 0; be1 = 0; addr1 = 0; wd1 = 0;
      repeat (3) @(negedge clk);
      chk("u0 reset outputs", {gnt0, rv0, err0, rd0} == '0,
          rd0 | 32'({gnt0, rv0, err0}), 32'd0);
      chk("u1 reset outputs", {gnt1, rv1, err1, rd1} == '0,
          rd1 | 32'({gnt1, rv1, err1}), 32'd0);
      @(posedge clk);
      #1;
      rst_n0 = 1'b1; rst_n1 = 1'b1;
      idle0(2);

      fork
         begin
            issue0(1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 0);
            issue0(0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 0);
            idle0(2);
            issue0(1, 32'h10, 4'b0001, 32'h000000AA, 32'h0, 0);
            issue0(1, 32'h10, 4'b0100, 32'h00CC0000, 32'h0, 0);
            issue0(0, 32'h10, 4'b0000, 32'h0, 32'hDECCBEAA, 0);
            idle0(2);
            issue0(1, 32'h0, 4'hF, 32'h11111111, 32'h0, 0);
            issue0(1, 32'h4, 4'hF, 32'h22222222, 32'h0, 0);
            issue0(1, 32'h8, 4'hF, 32'h33333333, 32'h0, 0);
            issue0(0, 32'h0, 4'hF, 32'h0, 32'h11111111, 0);
            issue0(0, 32'h4, 4'hF, 32'h0, 32'h22222222, 0);
            issue0(0, 32'h8, 4'hF, 32'h0, 32'h33333333, 0);
            idle0(2);
            issue0(1, 32'h1000, 4'hF, 32'h12345678, 32'h0, 1);
            issue0(0, 32'h0, 4'hF, 32'h0, 32'h11111111, 0);
            issue0(0, 32'hFFFFFFF0, 4'hF, 32'h0, 32'h0, 1);
            issue0(1, 32'h4, 4'h0, 32'hFFFFFFFF, 32'h0, 0);
            issue0(0, 32'h4, 4'hF, 32'h0, 32'h22222222, 0);
            idle0(4);
         end
         begin
            issue1(1, 32'h20, 32'hA5A50F0F, 32'h0, 1, n);
            chk("u1 gnt wait", n == 2, 32'(n), 32'd2);
            issue1(0, 32'h20, 32'h0, 32'hA5A50F0F, 1, n);
            chk("u1 gnt behind resp", n == 5, 32'(n), 32'd5);
            idle1(10);
            issue1(0, 32'h20, 32'h0, 32'hA5A50F0F, 0, n);
            rst_n1 = 1'b0;
            req1 = 1'b0;
            @(negedge clk);
            chk("u1 outputs in reset",
                {gnt1, rv1, err1, rd1} == '0,
                rd1 | 32'({gnt1, rv1, err1}), 32'd0);
            repeat (3) @(posedge clk);
            #1;
            rst_n1 = 1'b1;
            idle1(8);
            issue1(0, 32'h20, 32'h0, 32'hA5A50F0F, 1, n);
            chk("u1 gnt after reset", n == 2, 32'(n), 32'd2);
            idle1(8);
         end
      join

      repeat (10) @(posedge clk);
      #1;
      chk("u0 queue drained", q0.size() == 0,
          32'(q0.size()), 32'd0);
      chk("u1 queue drained", q1.size() == 0,
          32'(q1.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Responder end of the core's data-memory request/grant/rvalid interface: accepts the requests the load/store unit issues, commits byte-enabled writes, and returns read data with rvalid.
- Used as the data memory in core-level simulation and FPGA builds.
- Wait states are configurable so the initiator's stall handling can be exercised.
- At most one transaction is outstanding at a time.

Parameters:
WORD_WIDTH, 32, data and address width (shared constant from the defines package)
DEPTH_WORDS, 1024, memory size in words (power of two)
GNT_WAIT, 0, cycles req must be held before gnt is asserted (0 = gnt in the same cycle as req)
RESP_WAIT, 0, extra cycles between the grant cycle and rvalid (0 = rvalid in the cycle after the grant)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
data_req_i  in  1  request valid; held by the initiator until gnt
data_addr_i  in  WORD_WIDTH  byte address; bits [1:0] ignored
data_we_i  in  1  1 = write, 0 = read
data_be_i  in  4  byte-lane enables
data_wdata_i  in  WORD_WIDTH  write data, lane-aligned
data_gnt_o  out  1  address phase accepted
data_rvalid_o  out  1  response valid, one cycle per transaction (reads and writes)
data_rdata_o  out  WORD_WIDTH  read data, valid with rvalid
data_err_o  out  1  out-of-range access, valid with rvalid

Behaviour:
- Reset (async assert, sync release):
  - state IDLE, counters 0.
  - gnt, rvalid, err and rdata all 0.
  - Memory contents are not cleared.
- FSM states: IDLE, GNT_WAIT, RESP_WAIT, RESP.
- IDLE, req=1:
  - GNT_WAIT=0: gnt=1 combinationally. The grant cycle completes on this edge.
  - Otherwise: go to GNT_WAIT with wait_cnt cleared.
- GNT_WAIT:
  - wait_cnt increments each cycle req=1.
  - gnt=1 in the cycle wait_cnt==GNT_WAIT-1.
  - If req drops before gnt (protocol violation): return to IDLE, no memory effect.
- Grant edge (req&gnt):
  - Address, we and be are latched.
  - Writes commit on this edge, only lanes with be=1 (be=0 gives a no-op write that is still acknowledged).
  - Reads capture the full word on this edge regardless of be.
  - Next state: RESP if RESP_WAIT=0, else RESP_WAIT.
- RESP_WAIT: counts RESP_WAIT cycles, then goes to RESP.
- RESP:
  - rvalid=1 for exactly one cycle; rdata = captured word for reads, 0 for writes.
  - Back-to-back: in the RESP cycle the FSM behaves as IDLE for a new req. With GNT_WAIT=0, gnt may be high in the same cycle as rvalid, giving 1 transaction/cycle throughput when both waits are 0.
- rdata_o holds its last value while rvalid=0; only the cycle with rvalid=1 is defined.
- Word index = data_addr_i[2 +: log2(DEPTH_WORDS)].
- Out of range (data_addr_i >= 4*DEPTH_WORDS):
  - Write is dropped; read returns 0.
  - err=1 with rvalid; gnt timing is unchanged.
- Read-after-write to the same word on consecutive transactions returns the new data, since the write commits at its grant edge.
- gnt is never asserted while a response is still pending (RESP_WAIT state).
- Reset mid-transaction: the pending response is lost and any uncommitted write is discarded; a write already committed stays.

Decomposition:
- Defines package holds WORD_WIDTH and a dmem_state_t enum (IDLE, GNT_WAIT, RESP_WAIT, RESP).
- Sub-module dmem_sram_be: single-port synchronous RAM with per-byte write enables and registered read.
- The FSM, wait counters, range check and response registers stay in dmem_responder.

Test Plan:
- Waits 0/0: write 0xDEADBEEF to 0x10 with be=1111, then read 0x10. Gnt in the req cycle; rvalid on the next cycle; rdata=0xDEADBEEF; err=0.
- Byte lanes: with word 0x10=0xDEADBEEF, write 0x000000AA with be=0001, then 0x00CC0000 with be=0100. Read returns 0xDECCBEAA.
- GNT_WAIT=2, RESP_WAIT=3: read with req held. Gnt on the 3rd req cycle; rvalid exactly 4 cycles after the grant cycle, for 1 cycle.
- Back-to-back with waits 0/0: writes to 0x0, 0x4, 0x8 on three consecutive cycles. Gnt high on all three; rvalid on cycles 2-4; subsequent reads return the written data.
- Out of range, DEPTH_WORDS=1024: write 0x12345678 to 0x1000. rvalid=1, err=1; a read of 0x0000 is unchanged (word index wraps, but no aliasing write occurred).
- Reset mid-op, RESP_WAIT=3: assert rst_n=0 one cycle after a read's grant. No rvalid is ever produced; outputs are 0 during reset; after release a new read completes normally.
